mc_controller: RTL and testbench

//   Multi-cycle MIPS control FSM; successor to the single-cycle decoder. Sequences FETCH/DECODE/EXEC/MEM/WB
//   per instruction, decodes op/func from the instruction register, and emits per-state datapath strobes.

---
 rtl/mc_controller.sv | 213 +++++++++++++++++++++
 tb/tb_mc_controller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// ============================================================================
// Module      : mc_controller
// Description : Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with
//               variable-latency data memory handshake and timeout abort.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_controller #(
    parameter int ALU_CTRL_W  = 3,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            op,
    input  logic [5:0]            func,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic [1:0]            npc_sel,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic [1:0]            reg_dst,
    output logic [1:0]            mem_to_reg,
    output logic                  alu_src,
    output logic                  ext_op,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  illegal,
    output logic                  mem_err,
    output logic [2:0]            state
);

    localparam int CW = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [CW-1:0] c_CNT_LAST = CW'(MEM_TIMEOUT - 1);

    localparam logic [ALU_CTRL_W-1:0] c_ALU_ADD = ALU_CTRL_W'(3'b010);
    localparam logic [ALU_CTRL_W-1:0] c_ALU_SUB = ALU_CTRL_W'(3'b011);
    localparam logic [ALU_CTRL_W-1:0] c_ALU_OR  = ALU_CTRL_W'(3'b001);
    localparam logic [ALU_CTRL_W-1:0] c_ALU_LUI = ALU_CTRL_W'(3'b101);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;

    logic w_rtype, w_addu, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal;
    logic w_legal;

    assign w_rtype = (op == 6'b000000);
    assign w_addu  = w_rtype && (func == 6'b100001);
    assign w_subu  = w_rtype && (func == 6'b100011);
    assign w_jr    = w_rtype && (func == 6'b001000);
    assign w_ori   = (op == 6'b001101);
    assign w_lui   = (op == 6'b001111);
    assign w_lw    = (op == 6'b100011);
    assign w_sw    = (op == 6'b101011);
    assign w_beq   = (op == 6'b000100);
    assign w_j     = (op == 6'b000010);
    assign w_jal   = (op == 6'b000011);
    assign w_legal = w_addu | w_subu | w_jr | w_ori | w_lui | w_lw | w_sw |
                     w_beq | w_j | w_jal;

    // Datapath selects that depend only on the instruction, held DECODE..WB
    logic                  w_dp_src, w_dp_ext;
    logic [ALU_CTRL_W-1:0] w_dp_alu;

    always_comb begin
        w_dp_src = w_ori | w_lui | w_lw | w_sw;
        w_dp_ext = w_ori;
        w_dp_alu = c_ALU_ADD;
        if (w_subu || w_beq) w_dp_alu = c_ALU_SUB;
        else if (w_ori)      w_dp_alu = c_ALU_OR;
        else if (w_lui)      w_dp_alu = c_ALU_LUI;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    logic                  w_pc_write, w_ir_write, w_reg_write, w_alu_src, w_ext_op;
    logic                  w_mem_req, w_mem_we, w_illegal, w_mem_err;
    logic [1:0]            w_npc_sel, w_reg_dst, w_mem_to_reg;
    logic [ALU_CTRL_W-1:0] w_alu_ctrl;

    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt;
        w_pc_write   = 1'b0;
        w_npc_sel    = 2'b00;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_reg_dst    = 2'b00;
        w_mem_to_reg = 2'b00;
        w_alu_src    = 1'b0;
        w_ext_op     = 1'b0;
        w_alu_ctrl   = c_ALU_ADD;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_illegal    = 1'b0;
        w_mem_err    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                w_alu_src  = w_dp_src;
                w_ext_op   = w_dp_ext;
                w_alu_ctrl = w_dp_alu;
                w_reg_dst  = w_jal ? 2'b10 : (w_rtype ? 2'b01 : 2'b00);
                if (!w_legal) begin
                    w_illegal = 1'b1;
                    w_next    = S_FETCH;
                end else begin
                    w_next    = S_EXEC;
                end
            end
            S_EXEC: begin
                w_alu_src  = w_dp_src;
                w_ext_op   = w_dp_ext;
                w_alu_ctrl = w_dp_alu;
                w_cnt_next = '0;
                w_next     = S_FETCH;
                if (w_lw || w_sw) begin
                    w_next = S_MEM;
                end else if (w_beq) begin
                    w_pc_write = zero;
                    w_npc_sel  = 2'b01;
                end else if (w_j) begin
                    w_pc_write = 1'b1;
                    w_npc_sel  = 2'b10;
                end else if (w_jal) begin
                    w_pc_write   = 1'b1;
                    w_npc_sel    = 2'b10;
                    w_reg_write  = 1'b1;
                    w_reg_dst    = 2'b10;
                    w_mem_to_reg = 2'b10;
                end else if (w_jr) begin
                    w_pc_write = 1'b1;
                    w_npc_sel  = 2'b11;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_alu_src  = w_dp_src;
                w_ext_op   = w_dp_ext;
                w_alu_ctrl = w_dp_alu;
                // A ready arriving on the timeout cycle still completes normally
                if (mem_ready) begin
                    w_mem_req = 1'b1;
                    w_mem_we  = w_sw;
                    w_next    = w_sw ? S_FETCH : S_WB;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_mem_err = 1'b1;
                    w_next    = S_FETCH;
                end else begin
                    w_mem_req  = 1'b1;
                    w_mem_we   = w_sw;
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_WB: begin
                w_alu_src    = w_dp_src;
                w_ext_op     = w_dp_ext;
                w_alu_ctrl   = w_dp_alu;
                w_reg_write  = 1'b1;
                w_reg_dst    = w_rtype ? 2'b01 : 2'b00;
                w_mem_to_reg = w_lw ? 2'b01 : 2'b00;
                w_next       = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Reset forces every control output low immediately, independent of the clock
    assign pc_write   = w_pc_write  & ~reset;
    assign npc_sel    = reset ? 2'b00 : w_npc_sel;
    assign ir_write   = w_ir_write  & ~reset;
    assign reg_write  = w_reg_write & ~reset;
    assign reg_dst    = reset ? 2'b00 : w_reg_dst;
    assign mem_to_reg = reset ? 2'b00 : w_mem_to_reg;
    assign alu_src    = w_alu_src   & ~reset;
    assign ext_op     = w_ext_op    & ~reset;
    assign alu_ctrl   = reset ? '0 : w_alu_ctrl;
    assign mem_req    = w_mem_req   & ~reset;
    assign mem_we     = w_mem_we    & ~reset;
    assign illegal    = w_illegal   & ~reset;
    assign mem_err    = w_mem_err   & ~reset;
    assign state      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// ============================================================================
// Module      : tb_mc_controller
// Description : Scoreboard bench for mc_controller: directed instruction
//               sequences with hand-computed per-cycle control outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, func;
    logic       zero, mem_ready;
    logic       pc_write, ir_write, reg_write, alu_src, ext_op;
    logic       mem_req, mem_we, illegal, mem_err;
    logic [1:0] npc_sel, reg_dst, mem_to_reg;
    logic [2:0] alu_ctrl, state;

    mc_controller #(.ALU_CTRL_W(3), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .npc_sel(npc_sel),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .ext_op(ext_op),
        .alu_ctrl(alu_ctrl), .mem_req(mem_req), .mem_we(mem_we),
        .illegal(illegal), .mem_err(mem_err), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [20:0] exp;
        logic [20:0] mask;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic logic [20:0] v(input logic pcw, input logic [1:0] npc,
            input logic irw, input logic rw, input logic [1:0] rd,
            input logic [1:0] mtr, input logic src, input logic eo,
            input logic [2:0] ac, input logic mr, input logic mw,
            input logic il, input logic me, input logic [2:0] st);
        return {pcw, npc, irw, rw, rd, mtr, src, eo, ac, mr, mw, il, me, st};
    endfunction

    logic [20:0] M_CTRL, M_RD, M_MTR, M_AS, M_EO, M_AC, M_NPC, M_MW;
    logic [20:0] w_obs;
    assign w_obs = {pc_write, npc_sel, ir_write, reg_write, reg_dst, mem_to_reg,
                    alu_src, ext_op, alu_ctrl, mem_req, mem_we, illegal, mem_err, state};

    // Monitor: one expectation per cycle, checked on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                n_vec++;
                if ((w_obs & e.mask) !== (e.exp & e.mask)) begin
                    n_miss++;
                    $display("FAIL %s: got %h want %h (mask %h)", e.name,
                             w_obs & e.mask, e.exp & e.mask, e.mask);
                end
            end
        end
    end

    task automatic cyc(input string nm, input logic [20:0] e, input logic [20:0] m);
        q.push_back('{nm, e, m});
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string nm, input logic [5:0] o, input logic [5:0] f);
        op   = o;
        func = f;
        cyc({nm, ".F"}, v(1,0,1,0,0,0,0,0,0,0,0,0,0,0), M_CTRL);
    endtask

    task automatic decode_mem(input string nm);
        cyc({nm, ".D"}, v(0,0,0,0,0,0,1,0,2,0,0,0,0,1), M_CTRL | M_RD | M_AS | M_EO | M_AC);
        cyc({nm, ".E"}, v(0,0,0,0,0,0,1,0,2,0,0,0,0,2), M_CTRL | M_AS | M_EO | M_AC);
    endtask

    initial begin
        M_CTRL = v(1,3,1,1,0,0,0,0,0,1,1,1,1,7);
        M_RD   = v(0,0,0,0,3,0,0,0,0,0,0,0,0,0);
        M_MTR  = v(0,0,0,0,0,3,0,0,0,0,0,0,0,0);
        M_AS   = v(0,0,0,0,0,0,1,0,0,0,0,0,0,0);
        M_EO   = v(0,0,0,0,0,0,0,1,0,0,0,0,0,0);
        M_AC   = v(0,0,0,0,0,0,0,0,7,0,0,0,0,0);
        M_NPC  = v(0,3,0,0,0,0,0,0,0,0,0,0,0,0);
        M_MW   = v(0,0,0,0,0,0,0,0,0,0,1,0,0,0);
        reset = 1'b1; op = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset0", '0, M_CTRL);
        cyc("reset1", '0, M_CTRL);
        reset = 1'b0;

        issue("addu", 6'b000000, 6'b100001);
        cyc("addu.D", v(0,0,0,0,1,0,0,0,2,0,0,0,0,1), M_CTRL | M_RD | M_AS | M_AC);
        cyc("addu.E", v(0,0,0,0,0,0,0,0,0,0,0,0,0,2), M_CTRL);
        cyc("addu.WB", v(0,0,0,1,1,0,0,0,0,0,0,0,0,4), M_CTRL | M_RD | M_MTR);

        issue("subu", 6'b000000, 6'b100011);
        cyc("subu.D", v(0,0,0,0,1,0,0,0,3,0,0,0,0,1), M_CTRL | M_RD | M_AS | M_AC);
        cyc("subu.E", v(0,0,0,0,0,0,0,0,0,0,0,0,0,2), M_CTRL);
        cyc("subu.WB", v(0,0,0,1,1,0,0,0,0,0,0,0,0,4), M_CTRL | M_RD | M_MTR);

        issue("ori", 6'b001101, 6'b000000);
        cyc("ori.D", v(0,0,0,0,0,0,1,1,1,0,0,0,0,1), M_CTRL | M_RD | M_AS | M_EO | M_AC);
        cyc("ori.E", v(0,0,0,0,0,0,0,0,0,0,0,0,0,2), M_CTRL);
        cyc("ori.WB", v(0,0,0,1,0,0,0,0,0,0,0,0,0,4), M_CTRL | M_RD | M_MTR);

        issue("lui", 6'b001111, 6'b000000);
        cyc("lui.D", v(0,0,0,0,0,0,1,0,5,0,0,0,0,1), M_CTRL | M_RD | M_AS | M_AC);
        cyc("lui.E", v(0,0,0,0,0,0,0,0,0,0,0,0,0,2), M_CTRL);
        cyc("lui.WB", v(0,0,0,1,0,0,0,0,0,0,0,0,0,4), M_CTRL | M_RD | M_MTR);

        // lw with two wait cycles: 7 cycles total
        issue("lw2", 6'b100011, 6'b000000);
        decode_mem("lw2");
        cyc("lw2.M0", v(0,0,0,0,0,0,0,0,0,1,0,0,0,3), M_CTRL);
        cyc("lw2.M1", v(0,0,0,0,0,0,0,0,0,1,0,0,0,3), M_CTRL);
        mem_ready = 1'b1;
        cyc("lw2.M2", v(0,0,0,0,0,0,0,0,0,1,0,0,0,3), M_CTRL);
        mem_ready = 1'b0;
        cyc("lw2.WB", v(0,0,0,1,0,1,0,0,0,0,0,0,0,4), M_CTRL | M_RD | M_MTR);

        issue("lw0", 6'b100011, 6'b000000);
        decode_mem("lw0");
        mem_ready = 1'b1;
        cyc("lw0.M0", v(0,0,0,0,0,0,0,0,0,1,0,0,0,3), M_CTRL);
        mem_ready = 1'b0;
        cyc("lw0.WB", v(0,0,0,1,0,1,0,0,0,0,0,0,0,4), M_CTRL | M_RD | M_MTR);

        issue("beq1", 6'b000100, 6'b000000);
        cyc("beq1.D", v(0,0,0,0,0,0,0,0,3,0,0,0,0,1), M_CTRL | M_AS | M_AC);
        zero = 1'b1;
        cyc("beq1.E", v(1,1,0,0,0,0,0,0,3,0,0,0,0,2), M_CTRL | M_AC);
        zero = 1'b0;
        issue("beq0", 6'b000100, 6'b000000);
        cyc("beq0.D", v(0,0,0,0,0,0,0,0,3,0,0,0,0,1), M_CTRL | M_AS | M_AC);
        cyc("beq0.E", v(0,0,0,0,0,0,0,0,3,0,0,0,0,2), (M_CTRL & ~M_NPC) | M_AC);

        issue("j", 6'b000010, 6'b000000);
        cyc("j.D", v(0,0,0,0,0,0,0,0,0,0,0,0,0,1), M_CTRL);
        cyc("j.E", v(1,2,0,0,0,0,0,0,0,0,0,0,0,2), M_CTRL);

        issue("jal", 6'b000011, 6'b000000);
        cyc("jal.D", v(0,0,0,0,0,0,0,0,0,0,0,0,0,1), M_CTRL);
        cyc("jal.E", v(1,2,0,1,2,2,0,0,0,0,0,0,0,2), M_CTRL | M_RD | M_MTR);

        issue("jr", 6'b000000, 6'b001000);
        cyc("jr.D", v(0,0,0,0,0,0,0,0,0,0,0,0,0,1), M_CTRL);
        cyc("jr.E", v(1,3,0,0,0,0,0,0,0,0,0,0,0,2), M_CTRL);

        // sw with mem_ready never arriving: abort on 4th MEM cycle
        issue("swto", 6'b101011, 6'b000000);
        decode_mem("swto");
        for (int i = 0; i < 3; i++)
            cyc("swto.Mw", v(0,0,0,0,0,0,0,0,0,1,1,0,0,3), M_CTRL);
        cyc("swto.Merr", v(0,0,0,0,0,0,0,0,0,0,0,0,1,3), M_CTRL & ~M_MW);

        // ready on the timeout cycle wins
        issue("swrdy", 6'b101011, 6'b000000);
        decode_mem("swrdy");
        for (int i = 0; i < 3; i++)
            cyc("swrdy.Mw", v(0,0,0,0,0,0,0,0,0,1,1,0,0,3), M_CTRL);
        mem_ready = 1'b1;
        cyc("swrdy.Mlast", v(0,0,0,0,0,0,0,0,0,1,1,0,0,3), M_CTRL);
        mem_ready = 1'b0;

        issue("ill", 6'b111111, 6'b000000);
        cyc("ill.D", v(0,0,0,0,0,0,0,0,0,0,0,1,0,1), M_CTRL);
        issue("illR", 6'b000000, 6'b100000);
        cyc("illR.D", v(0,0,0,0,0,0,0,0,0,0,0,1,0,1), M_CTRL);

        // asynchronous reset in the middle of a memory wait
        issue("lwrst", 6'b100011, 6'b000000);
        decode_mem("lwrst");
        cyc("lwrst.M0", v(0,0,0,0,0,0,0,0,0,1,0,0,0,3), M_CTRL);
        reset = 1'b1;
        cyc("lwrst.R0", '0, M_CTRL);
        cyc("lwrst.R1", '0, M_CTRL);
        reset = 1'b0;

        issue("addu2", 6'b000000, 6'b100001);
        cyc("addu2.D", v(0,0,0,0,1,0,0,0,2,0,0,0,0,1), M_CTRL | M_RD | M_AS | M_AC);
        cyc("addu2.E", v(0,0,0,0,0,0,0,0,0,0,0,0,0,2), M_CTRL);
        cyc("addu2.WB", v(0,0,0,1,1,0,0,0,0,0,0,0,0,4), M_CTRL | M_RD | M_MTR);
        issue("end", 6'b000000, 6'b100001);

        @(negedge clk);
        #1;
        n_vec++;
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
